// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ valid/ready requesters. Define ARB_BURST_EN to let an owner keep
// the grant for up to MAX_BURST transfers; otherwise the grant rotates
// after every transfer.
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                            wr_clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data,
    output logic [NUM_REQ-1:0]              grant,
    output logic [ID_WIDTH-1:0]             grant_id,
    output logic                            busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Reject parameter sets the arbiter cannot represent.
    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_WIDTH) < NUM_REQ ||
        MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_cfg
        $error("fifo_wr_arbiter: illegal parameter set");
    end

`ifdef ARB_BURST_EN
    localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST) + 1;
    logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
`endif

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0]   last_id_q, last_id_d;
    logic                  busy_q, busy_d;

    logic                  owner_valid;
    logic [DATA_WIDTH-1:0] owner_word;
    logic                  pick_any;
    logic [ID_WIDTH-1:0]   pick_id;
    int unsigned           idx;
    logic                  transfer;
    logic                  last_beat;
    logic                  release_grant;

    // Owner's word and valid, selected by the one-hot grant.
    always_comb begin
        owner_word  = '0;
        owner_valid = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (grant_q[j]) begin
                owner_word  = req_data[j*DATA_WIDTH +: DATA_WIDTH];
                owner_valid = req_valid[j];
            end
        end
    end

    // Zero-latency write path, gated off by full and by reset.
    assign req_ready    = grant_q & {NUM_REQ{~fifo_full & ~reset}};
    assign fifo_wr_en   = |(req_valid & req_ready);
    assign fifo_wr_data = fifo_wr_en ? owner_word : '0;

    // Round-robin search starting after last_id; the current owner is visited last.
    always_comb begin
        pick_any = 1'b0;
        pick_id  = '0;
        idx      = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_id_q) + k) % NUM_REQ;
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!pick_any && idx == j && req_valid[j]) begin
                    pick_any = 1'b1;
                    pick_id  = ID_WIDTH'(j);
                end
            end
        end
    end

    // A transfer ends the grant unless bursting and below the burst limit.
    always_comb begin
`ifdef ARB_BURST_EN
        last_beat = (burst_cnt_q == CNT_WIDTH'(MAX_BURST - 1));
`else
        last_beat = 1'b1;
`endif
        transfer      = owner_valid & ~fifo_full;
        release_grant = ~owner_valid | (transfer & last_beat);
    end

    // Next-state logic: grant, re-grant without a bubble, or fall back to IDLE.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
`ifdef ARB_BURST_EN
        burst_cnt_d = burst_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    grant_d    = NUM_REQ'(1) << pick_id;
                    grant_id_d = pick_id;
                    last_id_d  = pick_id;
`ifdef ARB_BURST_EN
                    burst_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
                if (release_grant) begin
`ifdef ARB_BURST_EN
                    burst_cnt_d = '0;
`endif
                    if (pick_any) begin
                        grant_d    = NUM_REQ'(1) << pick_id;
                        grant_id_d = pick_id;
                        last_id_d  = pick_id;
                    end else begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        grant_id_d = '0;
                    end
                end else if (transfer) begin
`ifdef ARB_BURST_EN
                    burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == GRANT);
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_id_q  <= ID_WIDTH'(NUM_REQ - 1);
            busy_q     <= 1'b0;
`ifdef ARB_BURST_EN
            burst_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            busy_q     <= busy_d;
`ifdef ARB_BURST_EN
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule
